pulse_scheduler: RTL
====================

// Module: pulse_scheduler
// PURPOSE
//  Time-shares pulse generation between CHANNELS independent periodic sources.
//  Each channel has its own tick period; expiries queue as pending bits.
//  A round-robin arbiter issues them one at a time on a valid/ready event port.
//  Sits between the timebase enable (ena) and a single downstream event consumer.
// PARAMETERS
//  N         8  width of period (ticks) and per-channel counters
//  CHANNELS  4  number of channels, >=2; CW = $clog2(CHANNELS)
// PORTS
//  clk          in   1         clock, single domain
//  rst          in   1         asynchronous, active-high reset
//  ena          in   1         timebase tick; counters advance only when high
//  cfg_we       in   1         write config for channel cfg_ch this cycle
//  cfg_ch       in   CW        channel being configured
//  cfg_ticks    in   N         period value; expiry every cfg_ticks+1 ena cycles
//  cfg_enable   in   1         channel run enable
//  event_valid  out  1         an expiry event is presented
//  event_ready  in   1         consumer accepts event (handshake when both high)
//  event_ch     out  CW        channel of presented event
//  pending      out  CHANNELS  per-channel expiry awaiting issue
//  overrun      out  CHANNELS  sticky: expiry occurred while already pending
// BEHAVIOUR
//  Reset: all counters/ticks/enables 0, pending 0, overrun 0, event_valid 0,
//   event_ch 0, round-robin pointer 0, FSM IDLE. Reset mid-event drops the event.
//  Counter: per channel, if !enable: held at 0. Else on ena: if cnt==ticks ->
//   cnt<=0 and expiry fires; else cnt<=cnt+1. Compare is plain ==, no X-equality.
//   ticks=0 -> expiry every ena cycle. Counter wraps only through the compare.
//  Pending: expiry sets bit at the clock edge. Expiry while bit already set (and
//   not cleared this cycle) -> overrun bit set, pending stays 1 (events coalesce).
//  FSM IDLE: if any pending, pick first set bit at or after rr pointer (wrapping);
//   next edge: event_valid<=1, event_ch<=pick -> PRESENT. None pending: stay IDLE.
//   Latency: expiry at edge k -> event_valid high after edge k+1.
//  FSM PRESENT: event_valid and event_ch held stable until event_ready.
//   On handshake: clear pending[event_ch], rr pointer<=event_ch+1 (mod CHANNELS),
//   event_valid<=0, -> IDLE. At most one event per two cycles. No combinational
//   path from event_ready to event_valid.
//  Simultaneous handshake + new expiry on same channel: pending stays 1, no
//   overrun; the channel is re-arbitrated later at lowest priority.
//  cfg_we: loads ticks/enable for cfg_ch, clears its counter and overrun bit.
//   Also clears pending[cfg_ch] unless that channel is being presented (PRESENT
//   with event_ch==cfg_ch); a presented event always completes.
//   cfg_we takes priority over a same-cycle expiry of that channel (none fires).
//  cfg_ch >= CHANNELS (non-power-of-2 CHANNELS): write ignored.
// STRUCTURE
//  Package pulse_sched_pkg: state enum {IDLE, PRESENT}; default N/CHANNELS
//   constants; channel-index typedef.
//  Sub-module pulse_sched_channel: one counter/compare/ticks/enable register set
//   with expiry output, instantiated CHANNELS times via generate.
//  Arbiter, pending/overrun registers and FSM live in the top module.
// TESTING
//  1 ch0 ticks=3 en, ena=1 always, ready=1 -> event_ch=0 every 4 cycles,
//    first event_valid 2 cycles after first expiry.
//  2 ch0..3 all ticks=0 en, ready=1 -> grants 0,1,2,3,0,... in order;
//    all overrun bits set within the first 8 cycles.
//  3 ch1 ticks=1, ready=0 for 10 cycles -> valid held, event_ch=1 stable;
//    overrun[1]=1, pending[1]=1; raise ready -> single accept, then IDLE.
//  4 ena toggles 1/0 with ch2 ticks=2 -> expiry every 6 clocks; with ena=0 the
//    counters freeze and no events are issued.
//  5 cfg_we to ch3 while ch3 presented -> event completes; counter=0,
//    overrun[3]=0, new ticks used afterwards. cfg_we to a pending,
//    non-presented channel -> pending cleared and never issued.
//  6 assert rst mid-PRESENT (async, between edges) -> event_valid, pending,
//    overrun, counters all 0 immediately; normal operation after release.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared types and defaults for the pulse scheduler.
// Imported by the top module and the bench.
package pulse_sched_pkg;

  localparam int N_DEF  = 8;
  localparam int CH_DEF = 4;
  localparam int CW_DEF = $clog2(CH_DEF);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  typedef logic [CW_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/pulse_sched_channel.sv
// One periodic source: period register, run enable and tick counter.
// Expiry is combinational and is suppressed by a same-cycle config write.
module pulse_sched_channel #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         cfg_we,
  input  logic [N-1:0] cfg_ticks,
  input  logic         cfg_enable,
  output logic         expiry
);

  logic [N-1:0] r_ticks;
  logic [N-1:0] r_cnt;
  logic         r_en;
  logic         w_hit;

  assign w_hit  = (r_cnt == r_ticks);
  assign expiry = r_en & ena & w_hit & ~cfg_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ticks <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
    end else if (cfg_we) begin
      r_ticks <= cfg_ticks;
      r_en    <= cfg_enable;
      r_cnt   <= '0;
    end else if (!r_en) begin
      r_cnt <= '0;
    end else if (ena) begin
      r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Time-shares expiry events from CHANNELS periodic sources onto
// one valid/ready port through a round-robin arbiter.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int CHANNELS = CH_DEF,
  localparam int CW      = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [N-1:0]        cfg_ticks,
  input  logic                cfg_enable,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [CW-1:0]       event_ch,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overrun
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_event_valid;
  logic                w_valid_nxt;
  logic [CW-1:0]       r_event_ch;
  logic [CW-1:0]       w_ch_nxt;
  logic [CW-1:0]       r_rr;
  logic [CW-1:0]       w_rr_nxt;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_overrun;
  logic [CHANNELS-1:0] w_pend_nxt;
  logic [CHANNELS-1:0] w_ov_nxt;
  logic [CHANNELS-1:0] w_expiry;
  logic [CHANNELS-1:0] w_cfg_sel;
  logic [CHANNELS-1:0] w_pres;
  logic [CHANNELS-1:0] w_hs_clr;
  logic [CHANNELS-1:0] w_req;
  logic                w_hs;
  logic                w_found;
  logic [CW-1:0]       w_pick;

  assign w_hs        = r_event_valid & event_ready;
  assign event_valid = r_event_valid;
  assign event_ch    = r_event_ch;
  assign pending     = r_pending;
  assign overrun     = r_overrun;

  // Out-of-range cfg_ch matches no lane, so the write is dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_cfg_sel[g] = cfg_we && (cfg_ch == CW'(g));
    assign w_pres[g]    = (r_state == PRESENT) && (r_event_ch == CW'(g));
    assign w_hs_clr[g]  = w_hs && (r_event_ch == CW'(g));

    pulse_sched_channel #(
      .N (N)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .cfg_we     (w_cfg_sel[g]),
      .cfg_ticks  (cfg_ticks),
      .cfg_enable (cfg_enable),
      .expiry     (w_expiry[g])
    );
  end

  always_comb begin
    w_pend_nxt = r_pending;
    w_ov_nxt   = r_overrun;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_cfg_sel[i] && !w_pres[i]) begin
        w_pend_nxt[i] = 1'b0;
      end else if (w_expiry[i]) begin
        if (r_pending[i] && !w_hs_clr[i])
          w_ov_nxt[i] = 1'b1;
        w_pend_nxt[i] = 1'b1;
      end else if (w_hs_clr[i]) begin
        w_pend_nxt[i] = 1'b0;
      end
      if (w_cfg_sel[i])
        w_ov_nxt[i] = 1'b0;
    end
  end

  // Bits being wiped by a config write this cycle are not eligible.
  assign w_req = r_pending & ~(w_cfg_sel & ~w_pres);

  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= CHANNELS)
        idx = idx - CHANNELS;
      if (!w_found && w_req[idx]) begin
        w_found = 1'b1;
        w_pick  = CW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_event_valid;
    w_ch_nxt    = r_event_ch;
    w_rr_nxt    = r_rr;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = PRESENT;
          w_valid_nxt = 1'b1;
          w_ch_nxt    = w_pick;
        end
      end
      PRESENT: begin
        if (event_ready) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          if (r_event_ch == CW'(CHANNELS - 1))
            w_rr_nxt = '0;
          else
            w_rr_nxt = r_event_ch + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_event_valid <= 1'b0;
      r_event_ch    <= '0;
      r_rr          <= '0;
      r_pending     <= '0;
      r_overrun     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_event_valid <= w_valid_nxt;
      r_event_ch    <= w_ch_nxt;
      r_rr          <= w_rr_nxt;
      r_pending     <= w_pend_nxt;
      r_overrun     <= w_ov_nxt;
    end
  end

endmodule
